// File: rtl/mpu_counter.sv
// Instruction pointer for the MPU core: load, advance by a variable increment, or hold.
// Optional registered wrap flag on port carry when MPU_COUNTER_CARRY_EN is defined.
module mpu_counter #(
    parameter int WIDTH = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic [WIDTH-1:0] incr,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
`ifdef MPU_COUNTER_CARRY_EN
    output logic             carry,
`endif
    output logic [WIDTH-1:0] out
);

    // One extra bit so the wrap out of the MSB is visible to the carry flag.
    logic [WIDTH:0] sum;

    assign sum = {1'b0, out} + {1'b0, incr};

    // Load takes priority over advance; anything else holds.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            out <= '0;
        end else if (load) begin
            out <= data;
        end else if (en) begin
            out <= sum[WIDTH-1:0];
        end
    end

`ifdef MPU_COUNTER_CARRY_EN
    // Flag only the edge that actually wrapped; load and hold edges clear it.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            carry <= 1'b0;
        end else begin
            carry <= !load && en && sum[WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_mpu_counter.sv
// Self-checking bench for mpu_counter: reset, directed vector table, async reset, random run.
// Carry checks are enabled when MPU_COUNTER_CARRY_EN is defined.
module tb_mpu_counter;

    localparam int WIDTH = 16;

    typedef struct {
        logic             load;
        logic             en;
        logic [WIDTH-1:0] incr;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] exp_out;
        logic             exp_carry;
    } vec_t;

    logic             sys_clk;
    logic             sys_rst;
    logic             en;
    logic [WIDTH-1:0] incr;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] out;
    logic             carry;

    int checks = 0;
    int errors = 0;

    vec_t vecs[16];

    mpu_counter #(.WIDTH(WIDTH)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (en),
        .incr    (incr),
        .load    (load),
        .data    (data),
`ifdef MPU_COUNTER_CARRY_EN
        .carry   (carry),
`endif
        .out     (out)
    );

`ifndef MPU_COUNTER_CARRY_EN
    assign carry = 1'b0;
`endif

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_output(input string name, input logic [WIDTH-1:0] exp_out,
                                input logic exp_carry);
        check_value({name, ".out"}, 32'(out), 32'(exp_out));
`ifdef MPU_COUNTER_CARRY_EN
        check_value({name, ".carry"}, 32'(carry), 32'(exp_carry));
`else
        if (exp_carry === 1'bx) $display("[TB] unexpected X carry expectation in %s", name);
`endif
    endtask

    // Drive controls, then sample 1 ns after the rising edge that consumes them.
    task automatic apply_stimulus(input logic l, input logic e, input logic [WIDTH-1:0] inc,
                                  input logic [WIDTH-1:0] d);
        load = l;
        en   = e;
        incr = inc;
        data = d;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] model_out;
        logic             model_carry;
        logic [WIDTH:0]   model_sum;
        logic             r_load, r_en;
        logic [WIDTH-1:0] r_incr, r_data;

        //             load  en    incr      data      exp_out   exp_carry
        vecs[0]  = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h0008, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h0008, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 16'h0004, 16'h0004, 16'h0004, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 16'h0004, 16'h0000, 16'h0008, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'h0004, 16'h0000, 16'h000C, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h000C, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 16'h000C, 16'h000C, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 16'hFFFC, 16'hFFFC, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 16'h0004, 16'h0000, 16'h0000, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 16'h0004, 16'h0000, 16'h0004, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0003, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h0003, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 16'h0001, 16'h1234, 16'h1234, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 16'h8000, 16'h0000, 16'h9234, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 16'h8000, 16'h0000, 16'h1234, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0010, 1'b0};

        // Reset held with an active advance request: pointer must stay at zero.
        sys_rst = 1'b0;
        load    = 1'b0;
        en      = 1'b1;
        incr    = 16'h0004;
        data    = 16'h0000;
        repeat (3) @(posedge sys_clk);
        #1;
        check_output("reset_hold", 16'h0000, 1'b0);

        @(negedge sys_clk);
        sys_rst = 1'b1;
        apply_stimulus(1'b0, 1'b1, 16'h0004, 16'h0000);
        check_output("post_reset_1", 16'h0004, 1'b0);
        apply_stimulus(1'b0, 1'b1, 16'h0004, 16'h0000);
        check_output("post_reset_2", 16'h0008, 1'b0);

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i].load, vecs[i].en, vecs[i].incr, vecs[i].data);
            check_output($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_carry);
        end

        // Async reset between edges with out=0x0010 and advance pending.
        load = 1'b0;
        en   = 1'b1;
        incr = 16'h0004;
        #2;
        sys_rst = 1'b0;
        #1;
        check_output("async_reset", 16'h0000, 1'b0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        apply_stimulus(1'b0, 1'b1, 16'h0004, 16'h0000);
        check_output("async_release_1", 16'h0004, 1'b0);
        apply_stimulus(1'b0, 1'b1, 16'h0004, 16'h0000);
        check_output("async_release_2", 16'h0008, 1'b0);

        // Random run against the reference model.
        model_out   = 16'h0008;
        model_carry = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            r_load = ($urandom_range(0, 3) == 0);
            r_en   = ($urandom_range(0, 3) != 0);
            r_incr = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16))
                                                 : 16'($urandom);
            r_data = 16'($urandom);
            model_sum = {1'b0, model_out} + {1'b0, r_incr};
            if (r_load) begin
                model_out   = r_data;
                model_carry = 1'b0;
            end else if (r_en) begin
                model_out   = model_sum[WIDTH-1:0];
                model_carry = model_sum[WIDTH];
            end else begin
                model_carry = 1'b0;
            end
            apply_stimulus(r_load, r_en, r_incr, r_data);
            check_output($sformatf("rand%0d", i), model_out, model_carry);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
